spi_freq_tx: RTL and testbench
==============================

# spi_freq_tx

SPI master transmitter that serializes a 16-bit frequency word onto `sclk`/`cs`/`sdi`. It is the sending end of the link consumed by `lcdSPI`, which receives the frequency that `converter` turns into note/number characters for the LCD. The block is used on the FPGA side to drive a second board or a loopback fixture without the microcontroller. It also serves as the bus-functional stimulus source for `lcdSPI` regression.

## Interface
Parameters:
- `CLK_DIV`, default 12: `clk` cycles per `sclk` half-period; minimum 1. The default gives 1 MHz `sclk` from 24 MHz `clk`.
- `WIDTH`, default 16: frame length in bits.
- `MIN_GAP`, default 2: minimum `clk` cycles `cs` stays low between frames; minimum 1.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request to send `data`; sampled only while `busy`=0.
- `data` input WIDTH: word to send, MSB first; captured on the accepting cycle.
- `busy` output 1: high from the cycle after acceptance until the gap completes.
- `done` output 1: one-cycle pulse on the cycle `cs` deasserts.
- `sclk` output 1: SPI clock, mode 0, idles low.
- `cs` output 1: chip select, active-high, high for the whole frame.
- `sdi` output 1: serial data to the receiver.

## Operation
- State machine: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - `busy`=0, `cs`=0, `sclk`=0, `sdi`=0.
  - `start`=1 latches `data` into the shift register and bit counter = WIDTH-1; go to SETUP.
- SETUP:
  - `cs`=1, `sdi`=shift[WIDTH-1], `sclk`=0.
  - Hold CLK_DIV cycles, then raise `sclk`; enter SHIFT.
- SHIFT:
  - `sclk` toggles every CLK_DIV cycles.
  - On each falling `sclk`: if bit counter ≠ 0, shift left, present the next bit on `sdi`, and decrement the counter. If the counter is 0, go to HOLD with `sclk`=0.
  - Exactly WIDTH rising edges per frame. `sdi` never changes on a rising edge.
- HOLD: `cs`=1, `sclk`=0 for CLK_DIV cycles, then `cs`=0 and `done`=1 for one cycle; go to GAP.
- GAP: `cs`=0, `busy`=1 for MIN_GAP cycles counted from the `cs` fall; then IDLE.
- Arithmetic and width rules:
  - Half-period counter width is clog2(CLK_DIV+1); it wraps to 0 on each `sclk` edge.
  - Bit counter width is clog2(WIDTH).
  - No arithmetic on `data`.
- `start` while `busy`=1 is ignored and not queued. `data` changes after acceptance have no effect on the frame in flight.
- Reset:
  - Asserting `reset` in any state returns IDLE on the next edge, with all outputs 0 and counters 0.
  - A partial frame is abandoned; `cs` drops without a `done` pulse.
  - `reset` and `start` on the same edge: `reset` wins and the frame is not accepted.

## Timing
- Reset values: `busy`=0, `done`=0, `sclk`=0, `cs`=0, `sdi`=0.
- Cycle numbering: `start` accepted at cycle 0. From cycle 1: `cs`=1, `busy`=1, `sdi`=data[WIDTH-1].
- Rising `sclk` for bit k (k=0 is MSB) is registered at cycle 1+(2k+1)·CLK_DIV. Falling edges are at 1+(2k+2)·CLK_DIV.
- `sdi` for bit k is stable from the falling edge before rising edge k until the falling edge after it. Setup and hold are each CLK_DIV cycles.
- `cs` falls and `done` pulses at cycle 1+(2·WIDTH+1)·CLK_DIV. `busy` falls MIN_GAP cycles later.
- Earliest next accept is the cycle `busy` reads 0. Frame period = (2·WIDTH+1)·CLK_DIV + MIN_GAP + 1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset` 3 cycles, then release with `start`=0. Required: all outputs 0 for 10 cycles.
- Single frame, CLK_DIV=2, `data`=16'h00BD (189 Hz). Required:
  - `cs` high at cycle 1.
  - Rising `sclk` at cycles 3,7,…,63, sampling 0000000010111101.
  - `cs` falls and `done` pulses at cycle 67; `busy` falls at cycle 69.
- Back-to-back: hold `start`=1 with 16'hA5C3, then 16'h0001. Required:
  - Second frame accepted at cycle 69, so `cs` is low for exactly 3 cycles (67–69).
  - Both words recovered by an `lcdSPI` instance connected to the outputs.
- Busy ignore: pulse `start` with 16'hFFFF at cycle 20 of a 16'h1234 frame, and change `data` mid-frame. Required: only 16'h1234 is transmitted; no second frame follows.
- Reset mid-frame: assert `reset` at cycle 30. Required:
  - Next edge: `cs`=`sclk`=`sdi`=`busy`=0, and no `done` pulse.
  - A new `start` with 16'h0100 then sends a clean frame.
- Parameter corner, CLK_DIV=1, MIN_GAP=1, `data`=16'h8001. Required: `sclk` toggles every cycle, `cs` falls at cycle 34, and the bits are received correctly.

Source files
------------

// File: rtl/spi_freq_tx.sv
// SPI mode-0 master that serializes a frequency word MSB first.
// All outputs are registered from the current FSM state and counters.
module spi_freq_tx #(
    parameter int CLK_DIV = 12,
    parameter int WIDTH   = 16,
    parameter int MIN_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             sdi
);

    localparam int HC_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int GC_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [HC_W-1:0]  hc;
    logic [BC_W-1:0]  bc;
    logic [GC_W-1:0]  gc;
    logic [WIDTH-1:0] shreg;
    logic             ph;

    logic hc_last;
    logic gap_last;
    logic bc_zero;

    assign hc_last  = (hc == HC_W'(CLK_DIV - 1));
    assign gap_last = (gc == GC_W'(MIN_GAP - 1));
    assign bc_zero  = (bc == '0);

    logic o_busy;
    logic o_done;
    logic o_sclk;
    logic o_cs;
    logic o_sdi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = SETUP;
            SETUP: if (hc_last) state_nx = SHIFT;
            SHIFT: if (hc_last && ph && bc_zero) state_nx = HOLD;
            HOLD:  if (hc_last) state_nx = GAP;
            GAP:   if (gap_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ph is the internal sclk level; it flips whenever the half-period ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc    <= '0;
            bc    <= '0;
            gc    <= '0;
            shreg <= '0;
            ph    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    hc <= '0;
                    gc <= '0;
                    ph <= 1'b0;
                    if (start) begin
                        shreg <= data;
                        bc    <= BC_W'(WIDTH - 1);
                    end
                end
                SETUP: begin
                    if (hc_last) begin
                        hc <= '0;
                        ph <= 1'b1;
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end
                SHIFT: begin
                    if (hc_last) begin
                        hc <= '0;
                        ph <= ~ph;
                        if (ph && !bc_zero) begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            bc    <= bc - BC_W'(1);
                        end
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end
                HOLD: begin
                    if (hc_last) begin
                        hc <= '0;
                    end else begin
                        hc <= hc + HC_W'(1);
                    end
                end
                GAP: begin
                    gc <= gc + GC_W'(1);
                end
                default: begin
                    hc <= '0;
                    gc <= '0;
                    ph <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_sclk = 1'b0;
        o_cs   = 1'b0;
        o_sdi  = 1'b0;
        unique case (state)
            IDLE: ;
            SETUP, HOLD: begin
                o_busy = 1'b1;
                o_cs   = 1'b1;
                o_sdi  = shreg[WIDTH-1];
            end
            SHIFT: begin
                o_busy = 1'b1;
                o_cs   = 1'b1;
                o_sclk = ph;
                o_sdi  = shreg[WIDTH-1];
            end
            GAP: begin
                o_busy = 1'b1;
                o_done = (gc == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            sclk <= 1'b0;
            cs   <= 1'b0;
            sdi  <= 1'b0;
        end else begin
            busy <= o_busy;
            done <= o_done;
            sclk <= o_sclk;
            cs   <= o_cs;
            sdi  <= o_sdi;
        end
    end

endmodule

// File: tb/tb_spi_freq_tx.sv
// Directed bench for spi_freq_tx: one instance at CLK_DIV=2/MIN_GAP=2,
// one at CLK_DIV=1/MIN_GAP=1, each observed by a small SPI receiver.
module tb_spi_freq_tx;

    logic        clk;
    logic        reset;
    logic [1:0]  start_v;
    logic [15:0] data_v [2];
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [1:0]  sclk_v;
    logic [1:0]  cs_v;
    logic [1:0]  sdi_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 [2];

    spi_freq_tx #(.CLK_DIV(2), .WIDTH(16), .MIN_GAP(2)) u_a (
        .clk   (clk),
        .reset (reset),
        .start (start_v[0]),
        .data  (data_v[0]),
        .busy  (busy_v[0]),
        .done  (done_v[0]),
        .sclk  (sclk_v[0]),
        .cs    (cs_v[0]),
        .sdi   (sdi_v[0])
    );

    spi_freq_tx #(.CLK_DIV(1), .WIDTH(16), .MIN_GAP(1)) u_b (
        .clk   (clk),
        .reset (reset),
        .start (start_v[1]),
        .data  (data_v[1]),
        .busy  (busy_v[1]),
        .done  (done_v[1]),
        .sclk  (sclk_v[1]),
        .cs    (cs_v[1]),
        .sdi   (sdi_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver / timing monitor, sampled mid-cycle.
    logic [1:0]  p_sclk = '0;
    logic [1:0]  p_cs = '0;
    logic [1:0]  p_sdi = '0;
    logic [1:0]  p_busy = '0;
    logic [15:0] rx [2];
    logic [15:0] last_word [2];
    int nbits [2];
    int nrise [2];
    int first_rise [2];
    int last_rise [2];
    int bad_gap [2];
    int sdi_bad [2];
    int cs_rise [2];
    int cs_fall [2];
    int ncsrise [2];
    int nwords [2];
    int nabort [2];
    int ndone [2];
    int done_cyc [2];
    int busy_fall [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_v[i] && !p_cs[i]) begin
                nrise[i]   <= 0;
                nbits[i]   <= 0;
                rx[i]      <= '0;
                cs_rise[i] <= cyc - t0[i];
                ncsrise[i] <= ncsrise[i] + 1;
            end
            if (sclk_v[i] && !p_sclk[i]) begin
                nrise[i]     <= nrise[i] + 1;
                last_rise[i] <= cyc - t0[i];
                if (nrise[i] == 0)
                    first_rise[i] <= cyc - t0[i];
                else if (cyc - t0[i] - last_rise[i] != ((i == 0) ? 4 : 2))
                    bad_gap[i] <= bad_gap[i] + 1;
                if (sdi_v[i] !== p_sdi[i])
                    sdi_bad[i] <= sdi_bad[i] + 1;
                rx[i]    <= {rx[i][14:0], sdi_v[i]};
                nbits[i] <= nbits[i] + 1;
            end
            if (!cs_v[i] && p_cs[i]) begin
                cs_fall[i] <= cyc - t0[i];
                if (nbits[i] == 16) begin
                    last_word[i] <= rx[i];
                    nwords[i]    <= nwords[i] + 1;
                end else begin
                    nabort[i] <= nabort[i] + 1;
                end
            end
            if (done_v[i]) begin
                ndone[i]    <= ndone[i] + 1;
                done_cyc[i] <= cyc - t0[i];
            end
            if (!busy_v[i] && p_busy[i])
                busy_fall[i] <= cyc - t0[i];
        end
        p_sclk <= sclk_v;
        p_cs   <= cs_v;
        p_sdi  <= sdi_v;
        p_busy <= busy_v;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs(input int i);
        return {busy_v[i], done_v[i], sclk_v[i], cs_v[i], sdi_v[i]};
    endfunction

    // Accept on the next edge; that edge is cycle 0 of the frame.
    task automatic go(input int i, input logic [15:0] d);
        data_v[i]  = d;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        t0[i]      = cyc;
        start_v[i] = 1'b0;
    endtask

    task automatic at(input int i, input int n);
        while (cyc < t0[i] + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int i, input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (busy_v[i] !== 1'b0 && k < 500);
        chk({tag, "_tmo"}, {31'd0, busy_v[i]}, 32'd0);
        @(negedge clk);
        #1;
    endtask

    int s_words;
    int s_done;
    int s_abort;
    int s_cs;

    initial begin
        reset      = 1'b1;
        start_v    = '0;
        data_v[0]  = '0;
        data_v[1]  = '0;
        t0[0]      = 0;
        t0[1]      = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            chk("rst_a", {27'd0, outs(0)}, 32'd0);
            chk("rst_b", {27'd0, outs(1)}, 32'd0);
        end

        // Single frame 16'h00BD
        s_done = ndone[0];
        go(0, 16'h00BD);
        data_v[0] = 16'hFFFF;
        at(0, 1);
        chk("c1_cs", {31'd0, cs_v[0]}, 32'd1);
        chk("c1_busy", {31'd0, busy_v[0]}, 32'd1);
        chk("c1_sdi", {31'd0, sdi_v[0]}, 32'd0);
        chk("c1_sclk", {31'd0, sclk_v[0]}, 32'd0);
        wait_idle(0, "single");
        chk("s_first_rise", first_rise[0], 32'd3);
        chk("s_last_rise", last_rise[0], 32'd63);
        chk("s_nrise", nrise[0], 32'd16);
        chk("s_spacing", bad_gap[0], 32'd0);
        chk("s_sdi_on_rise", sdi_bad[0], 32'd0);
        chk("s_word", {16'd0, last_word[0]}, 32'h00BD);
        chk("s_cs_fall", cs_fall[0], 32'd67);
        chk("s_done_cyc", done_cyc[0], 32'd67);
        chk("s_ndone", ndone[0] - s_done, 32'd1);
        chk("s_busy_fall", busy_fall[0], 32'd69);

        // Back-to-back with start held high
        s_words    = nwords[0];
        data_v[0]  = 16'hA5C3;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        t0[0]     = cyc;
        data_v[0] = 16'h0001;
        at(0, 1);
        chk("b2b_sdi_msb", {31'd0, sdi_v[0]}, 32'd1);
        at(0, 69);
        start_v[0] = 1'b0;
        at(0, 71);
        chk("b2b_cs_fall", cs_fall[0], 32'd67);
        chk("b2b_cs_rise", cs_rise[0], 32'd70);
        chk("b2b_word1", {16'd0, last_word[0]}, 32'hA5C3);
        wait_idle(0, "b2b");
        chk("b2b_word2", {16'd0, last_word[0]}, 32'h0001);
        chk("b2b_nwords", nwords[0] - s_words, 32'd2);
        chk("b2b_sdi_on_rise", sdi_bad[0], 32'd0);

        // start while busy is ignored
        s_words = nwords[0];
        s_cs    = ncsrise[0];
        go(0, 16'h1234);
        at(0, 20);
        data_v[0]  = 16'hFFFF;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_idle(0, "ign");
        repeat (100) @(posedge clk);
        @(negedge clk);
        #1;
        chk("ign_word", {16'd0, last_word[0]}, 32'h1234);
        chk("ign_nwords", nwords[0] - s_words, 32'd1);
        chk("ign_ncs", ncsrise[0] - s_cs, 32'd1);

        // Reset in mid-frame abandons it without done
        s_done  = ndone[0];
        s_abort = nabort[0];
        go(0, 16'h5A5A);
        at(0, 29);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rmid_outs", {27'd0, outs(0)}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rmid_ndone", ndone[0] - s_done, 32'd0);
        chk("rmid_abort", nabort[0] - s_abort, 32'd1);

        // reset and start together: reset wins
        reset      = 1'b1;
        start_v[0] = 1'b1;
        data_v[0]  = 16'hFFFF;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_outs", {27'd0, outs(0)}, 32'd0);

        s_done = ndone[0];
        go(0, 16'h0100);
        wait_idle(0, "rclean");
        chk("rclean_word", {16'd0, last_word[0]}, 32'h0100);
        chk("rclean_ndone", ndone[0] - s_done, 32'd1);
        chk("rclean_nrise", nrise[0], 32'd16);

        // CLK_DIV=1, MIN_GAP=1 corner
        go(1, 16'h8001);
        at(1, 1);
        chk("k_c1_cs", {31'd0, cs_v[1]}, 32'd1);
        chk("k_c1_sdi", {31'd0, sdi_v[1]}, 32'd1);
        wait_idle(1, "corner");
        chk("k_first_rise", first_rise[1], 32'd2);
        chk("k_last_rise", last_rise[1], 32'd32);
        chk("k_nrise", nrise[1], 32'd16);
        chk("k_spacing", bad_gap[1], 32'd0);
        chk("k_sdi_on_rise", sdi_bad[1], 32'd0);
        chk("k_cs_fall", cs_fall[1], 32'd34);
        chk("k_done_cyc", done_cyc[1], 32'd34);
        chk("k_busy_fall", busy_fall[1], 32'd35);
        chk("k_word", {16'd0, last_word[1]}, 32'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
